id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high; no other clocks, no async reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 stall  in  1  hold all ID/EX state this cycle; flush  in  1  insert bubble this cycle.
REQ-005 id_valid  in  1; id_pc  in  32; id_imm  in  32; id_rdata1, id_rdata2  in  32 each: decoded instruction fields from ID.
REQ-006 id_rs1, id_rs2, id_rd  in  5 each; id_aluctrl  in  4  (ADD=0000 … SLTU=1001 encoding); id_alusrc  in  1  (1: src2=imm); id_asel_pc  in  1  (1: src1=pc); id_regwrite  in  1.
REQ-007 exm_regwrite  in  1; exm_rd  in  5; exm_result  in  32: EX/MEM forwarding source.
REQ-008 mwb_regwrite  in  1; mwb_rd  in  5; mwb_result  in  32: MEM/WB write-back and forwarding source.
REQ-009 ex_valid  out  1; ex_pc  out  32; ex_rd  out  5; ex_regwrite  out  1: registered EX-stage control.
REQ-010 src1, src2  out  32; aluctrl  out  4: ALU operands and opcode; ex_storedata  out  32: forwarded rs2 value.

Function
REQ-011 Register update priority at each rising clk edge SHALL be: rst > flush > stall > capture.
REQ-012 Capture (no rst/flush/stall) SHALL load all id_* fields into the stage registers in one cycle; latency ID→EX = 1 cycle.
REQ-013 Flush SHALL clear valid, regwrite, rd, rs1, rs2 to 0 and aluctrl to 0000 (ADD); other registers SHALL become 0.
REQ-014 Stall SHALL hold all stage registers except the write-back snoop of REQ-016.
REQ-015 Capture-time bypass: when mwb_regwrite=1, mwb_rd≠0 and mwb_rd==id_rs1 (resp. id_rs2), the stored rdata1 (rdata2) SHALL be mwb_result instead of id_rdata1 (id_rdata2).
REQ-016 Hold-time snoop: while stalled, when mwb_regwrite=1, mwb_rd≠0 and mwb_rd equals stored rs1 (rs2), stored rdata1 (rdata2) SHALL be overwritten with mwb_result.
REQ-017 Forwarding (combinational on stored state) for operand n in {1,2}: exm_regwrite=1, exm_rd≠0, exm_rd==stored rsn → exm_result; else mwb_regwrite=1, mwb_rd≠0, mwb_rd==stored rsn → mwb_result; else stored rdatan.
REQ-018 EX/MEM SHALL win over MEM/WB when both match; register x0 SHALL never be forwarded.
REQ-019 src1 SHALL be stored pc when stored asel_pc=1, else forwarded operand 1.
REQ-020 src2 SHALL be stored imm when stored alusrc=1, else forwarded operand 2; ex_storedata SHALL always be forwarded operand 2.
REQ-021 aluctrl, ex_pc, ex_rd SHALL be direct register outputs; ex_regwrite SHALL equal stored regwrite AND stored valid.
REQ-022 Simultaneous flush and stall SHALL flush; simultaneous stall and matching write-back SHALL hold and snoop.
REQ-023 Capture of id_valid=0 SHALL store a bubble with all other fields as presented (ex_regwrite forced 0 by REQ-021).

Reset
REQ-024 rst=1 at a clk edge SHALL zero every stage register; after reset ex_valid=0, ex_regwrite=0, ex_pc=0, ex_rd=0, aluctrl=0000, and with no forwarding match src1=src2=ex_storedata=0.
REQ-025 rst asserted mid-stall or with flush SHALL still produce REQ-024 state on that edge; no stored value survives reset.

Verification
REQ-026 Capture: id_rs1=3,id_rdata1=0x10,id_rs2=4,id_rdata2=0x20,aluctrl=0001, no fwd → next cycle src1=0x10, src2=0x20, aluctrl=0001, ex_valid=1.
REQ-027 Forward priority: stored rs1=5; exm_rd=5 result 0xAAAA, mwb_rd=5 result 0xBBBB, both regwrite=1 → src1=0xAAAA; drop exm_regwrite → src1=0xBBBB.
REQ-028 x0: stored rs2=0, exm_rd=0, exm_regwrite=1, exm_result=0xFFFF_FFFF, alusrc=0 → src2=stored rdata2 (0).
REQ-029 Stall snoop: stored rs1=7, rdata1=0x1; stall 3 cycles, mwb writes rd=7 value 0x55 in cycle 1 only → src1=0x55 in cycles 2-3 and after release.
REQ-030 Flush vs stall: stall=1, flush=1 with valid instr stored → next cycle ex_valid=0, ex_regwrite=0, aluctrl=0000, ex_rd=0.
REQ-031 Reset mid-operation: valid instr stored, stall=1, rst=1 → next cycle all outputs per REQ-024.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for a 5-stage RISC-style pipeline, with operand
// forwarding into the execute stage.
//
// The stage registers capture the decoded instruction from ID once per cycle.
// Each register is updated with this priority: reset, then flush (which
// inserts a bubble), then stall (which holds), then capture.
//
// While the stage is stalled it still watches the write-back port. A result
// retiring to one of its source registers is copied into the stored operand,
// so that value is not lost when the writer leaves MEM/WB. The same bypass
// applies at capture time, because the register file read in ID does not
// yet contain the value being written back in that cycle.
//
// Ports
//   clk, rst                      clock and synchronous active-high reset
//   stall, flush                  hold / bubble control from hazard logic
//   id_valid, id_pc, id_imm       decoded instruction from ID
//   id_rdata1, id_rdata2          register file read data
//   id_rs1, id_rs2, id_rd         register specifiers
//   id_aluctrl                    ALU opcode (ADD=0000 .. SLTU=1001)
//   id_alusrc                     1: src2 = immediate
//   id_asel_pc                    1: src1 = pc
//   id_regwrite                   instruction writes rd
//   exm_regwrite, exm_rd,
//   exm_result                    EX/MEM forwarding source
//   mwb_regwrite, mwb_rd,
//   mwb_result                    MEM/WB write-back and forwarding source
//   ex_valid, ex_pc, ex_rd,
//   ex_regwrite                   registered EX-stage control
//   src1, src2, aluctrl           ALU operands and opcode
//   ex_storedata                  forwarded rs2 value for stores
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_rdata1,
   input  logic [DATA_W-1:0] id_rdata2,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [4:0]        id_rd,
   input  logic [3:0]        id_aluctrl,
   input  logic              id_alusrc,
   input  logic              id_asel_pc,
   input  logic              id_regwrite,
   input  logic              exm_regwrite,
   input  logic [4:0]        exm_rd,
   input  logic [DATA_W-1:0] exm_result,
   input  logic              mwb_regwrite,
   input  logic [4:0]        mwb_rd,
   input  logic [DATA_W-1:0] mwb_result,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc,
   output logic [4:0]        ex_rd,
   output logic              ex_regwrite,
   output logic [DATA_W-1:0] src1,
   output logic [DATA_W-1:0] src2,
   output logic [3:0]        aluctrl,
   output logic [DATA_W-1:0] ex_storedata
);

   logic              vld_p0;
   logic [DATA_W-1:0] pc_p0;
   logic [DATA_W-1:0] imm_p0;
   logic [DATA_W-1:0] rdata1_p0;
   logic [DATA_W-1:0] rdata2_p0;
   logic [4:0]        rs1_p0;
   logic [4:0]        rs2_p0;
   logic [4:0]        rd_p0;
   logic [3:0]        aluctrl_p0;
   logic              alusrc_p0;
   logic              asel_pc_p0;
   logic              regwrite_p0;

   logic [DATA_W-1:0] fwd1;
   logic [DATA_W-1:0] fwd2;

   // A producer matches a source register only when it actually writes and
   // its destination is not x0, which always reads as zero.
   function automatic logic hit(input logic       we,
                                input logic [4:0] wrd,
                                input logic [4:0] rs);
      return we && (wrd != 5'd0) && (wrd == rs);
   endfunction

   // The younger EX/MEM result takes precedence over MEM/WB.
   function automatic logic [DATA_W-1:0] fwd_sel(input logic [4:0]        rs,
                                                 input logic [DATA_W-1:0] stored,
                                                 input logic              e_we,
                                                 input logic [4:0]        e_rd,
                                                 input logic [DATA_W-1:0] e_res,
                                                 input logic              w_we,
                                                 input logic [4:0]        w_rd,
                                                 input logic [DATA_W-1:0] w_res);
      if (hit(e_we, e_rd, rs))
         return e_res;
      else if (hit(w_we, w_rd, rs))
         return w_res;
      else
         return stored;
   endfunction

   // ---- ID -> EX stage boundary ----
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         vld_p0      <= 1'b0;
         pc_p0       <= '0;
         imm_p0      <= '0;
         rdata1_p0   <= '0;
         rdata2_p0   <= '0;
         rs1_p0      <= 5'd0;
         rs2_p0      <= 5'd0;
         rd_p0       <= 5'd0;
         aluctrl_p0  <= 4'b0000;
         alusrc_p0   <= 1'b0;
         asel_pc_p0  <= 1'b0;
         regwrite_p0 <= 1'b0;
      end else if (stall) begin
         if (hit(mwb_regwrite, mwb_rd, rs1_p0))
            rdata1_p0 <= mwb_result;
         if (hit(mwb_regwrite, mwb_rd, rs2_p0))
            rdata2_p0 <= mwb_result;
      end else begin
         vld_p0      <= id_valid;
         pc_p0       <= id_pc;
         imm_p0      <= id_imm;
         rdata1_p0   <= hit(mwb_regwrite, mwb_rd, id_rs1) ? mwb_result : id_rdata1;
         rdata2_p0   <= hit(mwb_regwrite, mwb_rd, id_rs2) ? mwb_result : id_rdata2;
         rs1_p0      <= id_rs1;
         rs2_p0      <= id_rs2;
         rd_p0       <= id_rd;
         aluctrl_p0  <= id_aluctrl;
         alusrc_p0   <= id_alusrc;
         asel_pc_p0  <= id_asel_pc;
         regwrite_p0 <= id_regwrite;
      end
   end

   // ---- EX stage operand selection ----
   always_comb begin
      fwd1 = fwd_sel(rs1_p0, rdata1_p0, exm_regwrite, exm_rd, exm_result,
                     mwb_regwrite, mwb_rd, mwb_result);
      fwd2 = fwd_sel(rs2_p0, rdata2_p0, exm_regwrite, exm_rd, exm_result,
                     mwb_regwrite, mwb_rd, mwb_result);
   end

   assign src1         = asel_pc_p0 ? pc_p0 : fwd1;
   assign src2         = alusrc_p0 ? imm_p0 : fwd2;
   assign ex_storedata = fwd2;
   assign aluctrl      = aluctrl_p0;
   assign ex_pc        = pc_p0;
   assign ex_rd        = rd_p0;
   assign ex_valid     = vld_p0;
   assign ex_regwrite  = regwrite_p0 & vld_p0;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   logic        clk;
   logic        rst, stall, flush;
   logic        id_valid;
   logic [31:0] id_pc, id_imm, id_rdata1, id_rdata2;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_aluctrl;
   logic        id_alusrc, id_asel_pc, id_regwrite;
   logic        exm_regwrite;
   logic [4:0]  exm_rd;
   logic [31:0] exm_result;
   logic        mwb_regwrite;
   logic [4:0]  mwb_rd;
   logic [31:0] mwb_result;
   logic        ex_valid, ex_regwrite;
   logic [31:0] ex_pc, src1, src2, ex_storedata;
   logic [4:0]  ex_rd;
   logic [3:0]  aluctrl;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          cyc;
      string       name;
      logic        v;
      logic        rw;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [3:0]  alu;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] sd;
   } exp_t;

   exp_t sb[$];

   id_ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
      .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_aluctrl(id_aluctrl), .id_alusrc(id_alusrc),
      .id_asel_pc(id_asel_pc), .id_regwrite(id_regwrite),
      .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
      .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .src1(src1), .src2(src2),
      .aluctrl(aluctrl), .ex_storedata(ex_storedata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: after every rising edge, compare the outputs against every
   // scoreboard entry due on this cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
               errors++;
               $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                        e.name, e.cyc, cyc);
            end else if ({ex_valid, ex_regwrite, ex_pc, ex_rd, aluctrl, src1, src2, ex_storedata}
                         !== {e.v, e.rw, e.pc, e.rd, e.alu, e.s1, e.s2, e.sd}) begin
               errors++;
               $display("FAIL %s: got v=%0b rw=%0b pc=%h rd=%0d alu=%h s1=%h s2=%h sd=%h want v=%0b rw=%0b pc=%h rd=%0d alu=%h s1=%h s2=%h sd=%h",
                        e.name, ex_valid, ex_regwrite, ex_pc, ex_rd, aluctrl, src1, src2, ex_storedata,
                        e.v, e.rw, e.pc, e.rd, e.alu, e.s1, e.s2, e.sd);
            end
         end
      end
   end

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [4:0] rs1, input logic [31:0] rd1,
                         input logic [4:0] rs2, input logic [31:0] rd2,
                         input logic [4:0] rd, input logic [3:0] alu,
                         input logic alusrc, input logic asel, input logic rw);
      id_valid = v;       id_pc = pc;          id_imm = imm;
      id_rs1 = rs1;       id_rdata1 = rd1;
      id_rs2 = rs2;       id_rdata2 = rd2;
      id_rd = rd;         id_aluctrl = alu;
      id_alusrc = alusrc; id_asel_pc = asel;   id_regwrite = rw;
   endtask

   task automatic set_fwd(input logic ewe, input logic [4:0] erd, input logic [31:0] eres,
                          input logic wwe, input logic [4:0] wrd, input logic [31:0] wres);
      exm_regwrite = ewe; exm_rd = erd; exm_result = eres;
      mwb_regwrite = wwe; mwb_rd = wrd; mwb_result = wres;
   endtask

   task automatic set_ctl(input logic r, input logic s, input logic f);
      rst = r; stall = s; flush = f;
   endtask

   // Issue the inputs already driven for the next edge and record what the
   // outputs must show just after it, then move to the next falling edge.
   task automatic expect_out(input string name, input logic v, input logic rw,
                             input logic [31:0] pc, input logic [4:0] rd,
                             input logic [3:0] alu, input logic [31:0] s1,
                             input logic [31:0] s2, input logic [31:0] sd);
      exp_t e;
      e.cyc = cyc + 1; e.name = name;
      e.v = v; e.rw = rw; e.pc = pc; e.rd = rd; e.alu = alu;
      e.s1 = s1; e.s2 = s2; e.sd = sd;
      sb.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      set_ctl(1, 0, 0);
      set_id(1, 32'hDEAD_0000, 32'h1234, 5'd1, 32'h1111, 5'd2, 32'h2222, 5'd3, 4'h5, 0, 0, 1);
      set_fwd(0, 0, 0, 0, 0, 0);
      @(negedge clk);

      // Reset with a valid instruction presented
      expect_out("reset", 0, 0, 0, 0, 4'h0, 0, 0, 0);

      // Plain capture, no forwarding
      set_ctl(0, 0, 0);
      set_id(1, 32'h100, 32'h7, 5'd3, 32'h10, 5'd4, 32'h20, 5'd9, 4'h1, 0, 0, 1);
      expect_out("capture", 1, 1, 32'h100, 5'd9, 4'h1, 32'h10, 32'h20, 32'h20);

      // Instruction with rs1=5, immediate second operand
      set_id(1, 32'h104, 32'h8, 5'd5, 32'h11, 5'd6, 32'h22, 5'd5, 4'h2, 1, 0, 1);
      expect_out("capture_imm", 1, 1, 32'h104, 5'd5, 4'h2, 32'h11, 32'h8, 32'h22);

      // Held by stall while ID shows junk; both forward sources match rs1
      set_ctl(0, 1, 0);
      set_id(1, 32'hFFF0, 32'hFF, 5'd1, 32'hEE, 5'd2, 32'hDD, 5'd30, 4'h9, 0, 1, 0);
      set_fwd(1, 5'd5, 32'hAAAA, 1, 5'd5, 32'hBBBB);
      expect_out("fwd_exm_wins", 1, 1, 32'h104, 5'd5, 4'h2, 32'hAAAA, 32'h8, 32'h22);

      set_fwd(0, 5'd5, 32'hAAAA, 1, 5'd5, 32'hBBBB);
      expect_out("fwd_mwb", 1, 1, 32'h104, 5'd5, 4'h2, 32'hBBBB, 32'h8, 32'h22);

      // Forwarding gone: the value snooped while stalled must remain
      set_fwd(0, 0, 0, 0, 0, 0);
      expect_out("snoop_kept", 1, 1, 32'h104, 5'd5, 4'h2, 32'hBBBB, 32'h8, 32'h22);

      // x0 is never forwarded
      set_ctl(0, 0, 0);
      set_id(1, 32'h108, 32'h0, 5'd1, 32'h33, 5'd0, 32'h0, 5'd2, 4'h3, 0, 0, 1);
      expect_out("capture_x0", 1, 1, 32'h108, 5'd2, 4'h3, 32'h33, 32'h0, 32'h0);

      set_ctl(0, 1, 0);
      set_fwd(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hDEAD);
      expect_out("x0_no_fwd", 1, 1, 32'h108, 5'd2, 4'h3, 32'h33, 32'h0, 32'h0);

      // Capture-time bypass of rs2 from write-back
      set_ctl(0, 0, 0);
      set_id(1, 32'h10C, 32'h0, 5'd7, 32'h1, 5'd8, 32'h2, 5'd7, 4'h4, 0, 0, 1);
      set_fwd(0, 0, 0, 1, 5'd8, 32'h77);
      expect_out("capture_bypass", 1, 1, 32'h10C, 5'd7, 4'h4, 32'h1, 32'h77, 32'h77);

      // Three stalled cycles; rd=7 written back only in the first
      set_ctl(0, 1, 0);
      set_id(0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 4'h0, 0, 0, 0);
      set_fwd(0, 0, 0, 1, 5'd7, 32'h55);
      expect_out("stall1", 1, 1, 32'h10C, 5'd7, 4'h4, 32'h55, 32'h77, 32'h77);
      set_fwd(0, 0, 0, 0, 0, 0);
      expect_out("stall2", 1, 1, 32'h10C, 5'd7, 4'h4, 32'h55, 32'h77, 32'h77);
      expect_out("stall3", 1, 1, 32'h10C, 5'd7, 4'h4, 32'h55, 32'h77, 32'h77);

      // Flush together with stall wins
      set_ctl(0, 0, 0);
      set_id(1, 32'h200, 32'h9, 5'd1, 32'h5, 5'd2, 32'h6, 5'd3, 4'h5, 0, 0, 1);
      expect_out("capture_pre_flush", 1, 1, 32'h200, 5'd3, 4'h5, 32'h5, 32'h6, 32'h6);
      set_ctl(0, 1, 1);
      expect_out("flush_and_stall", 0, 0, 0, 0, 4'h0, 0, 0, 0);

      // Bubble keeps its fields but never writes
      set_ctl(0, 0, 0);
      set_id(0, 32'h300, 32'hC, 5'd2, 32'h9, 5'd3, 32'hA, 5'd4, 4'h6, 1, 0, 1);
      expect_out("bubble", 0, 0, 32'h300, 5'd4, 4'h6, 32'h9, 32'hC, 32'hA);

      // PC as first operand
      set_id(1, 32'h400, 32'h0, 5'd1, 32'h99, 5'd2, 32'h3, 5'd10, 4'h9, 0, 1, 1);
      expect_out("asel_pc", 1, 1, 32'h400, 5'd10, 4'h9, 32'h400, 32'h3, 32'h3);

      // Reset during a stall clears everything
      set_ctl(1, 1, 0);
      expect_out("reset_in_stall", 0, 0, 0, 0, 4'h0, 0, 0, 0);

      // Flush alone
      set_ctl(0, 0, 0);
      set_id(1, 32'h500, 32'h4, 5'd6, 32'h61, 5'd7, 32'h71, 5'd8, 4'h7, 0, 0, 1);
      expect_out("capture_pre_flush2", 1, 1, 32'h500, 5'd8, 4'h7, 32'h61, 32'h71, 32'h71);
      set_ctl(0, 0, 1);
      expect_out("flush_only", 0, 0, 0, 0, 4'h0, 0, 0, 0);

      set_ctl(0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
